uart_tx: RTL and testbench

- 8N1 UART transmitter with a small byte FIFO, LSB first.
- Outgoing counterpart of the serial receiver feeding the ICCM programming path.
- Lets on-chip logic send status and echo bytes back to the host programmer.
- Byte-stream valid/ready input on the write side; single serial output line on the other side.

---
 rtl/uart_tx.sv | 103 ++++++++++
 tb/tb_uart_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter fed by a small byte FIFO
module uart_tx #(
  parameter int FifoDepth = 4,
  parameter int LvlW      = $clog2(FifoDepth + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [15:0]     clks_per_bit_i,
  input  logic            tx_valid_i,
  input  logic [7:0]      tx_byte_i,
  output logic            tx_ready_o,
  output logic            tx_serial_o,
  output logic            tx_active_o,
  output logic            tx_done_o,
  output logic [LvlW-1:0] fifo_level_o
);
  localparam int PtrW = $clog2(FifoDepth);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e          state_q, state_d;
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     n_q, n_d, cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            serial_q, serial_d, active_q, active_d, done_q, done_d;
  logic            push, pop, last;
  assign tx_ready_o   = !reset && (level_q != LvlW'(FifoDepth));
  assign tx_serial_o  = serial_q;
  assign tx_active_o  = active_q;
  assign tx_done_o    = done_q;
  assign fifo_level_o = level_q;
  always_comb begin
    push     = tx_valid_i && tx_ready_o;
    last     = cnt_q == n_q - 16'd1;
    pop      = (level_q != '0) && (state_q == IDLE || (state_q == STOP && last));
    state_d  = state_q;
    shift_d  = shift_q;
    n_d      = n_q;
    cnt_d    = last ? 16'd0 : cnt_q + 16'd1;
    bit_d    = bit_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE:  cnt_d = 16'd0;
      START: if (last) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA:  if (last) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP:  if (last) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a pop from IDLE or the final STOP cycle starts the next frame immediately
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      n_d     = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
      cnt_d   = 16'd0;
      state_d = START;
    end
    serial_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    active_d = state_d != IDLE;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    level_d  = level_q + LvlW'(push) - LvlW'(pop);
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_byte_i;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      shift_q  <= '0;
      n_q      <= 16'd1;
      cnt_q    <= '0;
      bit_q    <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      shift_q  <= shift_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a byte/period scoreboard checked by a frame-capturing monitor
module tb_uart_tx;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] clks = 16'd4;
  logic        valid = 1'b0;
  logic [7:0]  byte_i = 8'd0;
  logic        ready, serial, active, done;
  logic [2:0]  level;
  int          errors = 0;
  int          checks = 0;
  typedef struct {logic [7:0] b; int n;} exp_t;
  exp_t        exp_q[$];
  exp_t        me;
  logic        fbuf [0:1023];
  int          flen = 0;
  logic [9:0]  got, want;
  logic        stable;
  uart_tx #(.FifoDepth(4)) dut (
    .clock(clock), .reset(reset), .clks_per_bit_i(clks),
    .tx_valid_i(valid), .tx_byte_i(byte_i), .tx_ready_o(ready),
    .tx_serial_o(serial), .tx_active_o(active), .tx_done_o(done),
    .fifo_level_o(level)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // capture every active cycle; a done pulse closes the frame and it is scored
  always @(negedge clock) begin
    if (reset) flen = 0;
    else begin
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          me = exp_q.pop_front();
          chk("frame_len", flen, 10 * me.n);
          want = {1'b1, me.b, 1'b0};
          got = '0;
          stable = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 0; j < me.n; j++)
              if (k * me.n + j < flen) begin
                if (j == 0) got[k] = fbuf[k * me.n];
                else if (fbuf[k * me.n + j] !== fbuf[k * me.n]) stable = 1'b0;
              end
          chk("frame_bits", got, want);
          chk("bit_stable", stable, 1);
        end
        flen = 0;
      end
      if (active && flen < 1024) begin
        fbuf[flen] = serial;
        flen++;
      end
    end
  end
  task automatic send(input logic [7:0] b, input int n);
    valid = 1'b1;
    byte_i = b;
    @(negedge clock);
    chk("ready_on_send", ready, 1);
    @(posedge clock);
    exp_q.push_back('{b, n});
    #1 valid = 1'b0;
  endtask
  task automatic wait_start(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clock);
      if (serial === 1'b0) break;
    end
    chk("start_timeout", i < budget, 1);
  endtask
  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!active && exp_q.size() == 0 && level == 0) break;
    end
    chk("idle_timeout", i < budget, 1);
  endtask
  initial begin
    int act, d1, d2, bad;
    repeat (2) @(negedge clock);
    chk("rst_serial", serial, 1);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", ready, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("ready_after_rst", ready, 1);
    // 1: single frame, start bit at C+2
    clks = 16'd4;
    @(posedge clock); #1;
    send(8'hA5, 4);
    @(negedge clock);
    chk("t1_c1_serial", serial, 1);
    chk("t1_c1_active", active, 0);
    chk("t1_c1_level", level, 1);
    @(negedge clock);
    chk("t1_c2_serial", serial, 0);
    chk("t1_c2_active", active, 1);
    wait_idle(100);
    // 2: back-to-back frames
    clks = 16'd3;
    @(posedge clock); #1;
    send(8'h00, 3);
    send(8'hFF, 3);
    wait_start(10);
    act = 0; d1 = -1; d2 = -1;
    for (int i = 0; i < 100; i++) begin
      if (active) act++;
      if (done) begin
        if (d1 < 0) d1 = i;
        else d2 = i;
      end
      @(negedge clock);
    end
    chk("t2_active_cycles", act, 60);
    chk("t2_done1", d1, 30);
    chk("t2_done2", d2, 60);
    wait_idle(50);
    // 3: overfill the FIFO
    clks = 16'd8;
    @(posedge clock); #1;
    for (int i = 0; i < 7; i++) begin
      valid = 1'b1;
      byte_i = 8'(i + 1);
      @(negedge clock);
      chk("t3_ready", ready, i < 5);
      @(posedge clock);
      if (i < 5) exp_q.push_back('{8'(i + 1), 8});
      #1;
    end
    valid = 1'b0;
    @(negedge clock);
    chk("t3_level_full", level, 4);
    chk("t3_ready_full", ready, 0);
    wait_idle(600);
    // 4: reset during data bit 3 with two bytes queued
    clks = 16'd4;
    @(posedge clock); #1;
    send(8'h5A, 4);
    send(8'h11, 4);
    send(8'h22, 4);
    @(negedge clock);
    chk("t4_start", serial, 0);
    chk("t4_level", level, 2);
    repeat (15) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("t4_ready_in_rst", ready, 0);
    @(posedge clock); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("t4_serial", serial, 1);
    chk("t4_level0", level, 0);
    chk("t4_ready", ready, 1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (serial !== 1'b1 || active !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clock);
    end
    chk("t4_quiet", bad, 0);
    // 5: bit period change mid-frame
    clks = 16'd5;
    @(posedge clock); #1;
    send(8'hC3, 5);
    send(8'h96, 9);
    wait_start(10);
    repeat (20) @(negedge clock);
    clks = 16'd9;
    wait_idle(300);
    // 6: zero period treated as one
    clks = 16'd0;
    @(posedge clock); #1;
    send(8'h3C, 1);
    wait_idle(50);
    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
